// File: rtl/nes_bus_pkg.sv
// Shared decode constants, address-region and controller-state types for the CPU bus responder.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_JOY1,
    RGN_JOY2,
    RGN_PRG,
    RGN_OPEN
  } region_e;

  typedef enum logic [1:0] {
    JOY_LOAD,
    JOY_SHIFT,
    JOY_DRAINED
  } joy_state_e;

  localparam logic [15:0] RAM_END   = 16'h1FFF;
  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;
  localparam logic [15:0] PRG_BASE  = 16'h8000;

  // $4017 falls through to open bus when the second controller is not built.
  function automatic region_e decode_region(input logic [15:0] a, input logic joy2_en);
    region_e r;
    if (a <= RAM_END)                  r = RGN_RAM;
    else if (a == JOY1_ADDR)           r = RGN_JOY1;
    else if (a == JOY2_ADDR && joy2_en) r = RGN_JOY2;
    else if (a >= PRG_BASE)            r = RGN_PRG;
    else                               r = RGN_OPEN;
    return r;
  endfunction

endpackage

// File: rtl/joy_shift.sv
// One controller port: parallel-load while strobe is high, then LSB-first serial readout,
// returning 1 once all buttons have been shifted out.
module joy_shift
  import nes_bus_pkg::*;
#(
  parameter int JOY_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic                rd_pulse,
  input  logic [JOY_BITS-1:0] btn,
  output logic                bit_o
);

  localparam int CW = $clog2(JOY_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(JOY_BITS - 1);

  joy_state_e          state_q, state_d;
  logic [JOY_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= JOY_SHIFT;
      sr_q    <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // strobe is the value taking effect at this edge, so a 1->0 write still loads once.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      JOY_LOAD: begin
        sr_d  = btn;
        cnt_d = '0;
        if (!strobe) state_d = JOY_SHIFT;
      end
      JOY_SHIFT: begin
        if (strobe) begin
          state_d = JOY_LOAD;
          sr_d    = btn;
          cnt_d   = '0;
        end else if (rd_pulse) begin
          sr_d  = {1'b1, sr_q[JOY_BITS-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = JOY_DRAINED;
        end
      end
      JOY_DRAINED: begin
        if (strobe) begin
          state_d = JOY_LOAD;
          sr_d    = btn;
          cnt_d   = '0;
        end
      end
      default: state_d = JOY_SHIFT;
    endcase
  end

  assign bit_o = (state_q == JOY_LOAD)    ? btn[0] :
                 (state_q == JOY_DRAINED) ? 1'b1   : sr_q[0];

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus slave: mirrored work RAM, controller ports and PRG ROM, registered read data with open bus.
// Define JOY2_EN to build the second controller at $4017 (adds port joy2_btn).
module cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int RAM_AW   = 11,
  parameter int PRG_AW   = 15,
  parameter int JOY_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         addr,
  input  logic                we,
  input  logic [7:0]          d_wr,
  output logic [7:0]          d_rd,
  output logic [PRG_AW-1:0]   prg_addr,
  input  logic [7:0]          prg_data,
`ifdef JOY2_EN
  input  logic [JOY_BITS-1:0] joy2_btn,
`endif
  input  logic [JOY_BITS-1:0] joy1_btn
);

`ifdef JOY2_EN
  localparam logic JOY2_ON = 1'b1;
`else
  localparam logic JOY2_ON = 1'b0;
`endif

  region_e    rgn;
  logic [7:0] ram_q [2**RAM_AW];
  logic [7:0] d_rd_q, d_rd_d;
  logic       strobe_q, strobe_d;
  logic       joy1_bit, joy2_bit;

  assign rgn      = decode_region(addr, JOY2_ON);
  assign prg_addr = addr[PRG_AW-1:0];
  assign d_rd     = d_rd_q;

  joy_shift #(.JOY_BITS(JOY_BITS)) u_joy1 (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe_d),
    .rd_pulse (!we && rgn == RGN_JOY1),
    .btn      (joy1_btn),
    .bit_o    (joy1_bit)
  );

`ifdef JOY2_EN
  joy_shift #(.JOY_BITS(JOY_BITS)) u_joy2 (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe_d),
    .rd_pulse (!we && rgn == RGN_JOY2),
    .btn      (joy2_btn),
    .bit_o    (joy2_bit)
  );
`else
  assign joy2_bit = 1'b1;
`endif

  // Unmapped reads and all writes leave d_rd untouched, which models open bus.
  always_comb begin
    strobe_d = strobe_q;
    d_rd_d   = d_rd_q;
    if (we) begin
      if (rgn == RGN_JOY1) strobe_d = d_wr[0];
    end else begin
      case (rgn)
        RGN_RAM:  d_rd_d = ram_q[addr[RAM_AW-1:0]];
        RGN_JOY1: d_rd_d = {7'b0, joy1_bit};
        RGN_JOY2: d_rd_d = {7'b0, joy2_bit};
        RGN_PRG:  d_rd_d = prg_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_rd_q   <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      d_rd_q   <= d_rd_d;
      strobe_q <= strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && rgn == RGN_RAM) ram_q[addr[RAM_AW-1:0]] <= d_wr;
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized bench for cpu_bus_responder (PRG_AW=14) against a read-index based bus model.
module tb_cpu_bus_responder;

  localparam int PRG_AW = 14;
`ifdef JOY2_EN
  localparam bit JOY2 = 1'b1;
`else
  localparam bit JOY2 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       addr = 16'h2000;
  logic              we = 1'b0;
  logic [7:0]        d_wr = 8'h00;
  logic [7:0]        d_rd;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_data;
  logic [7:0]        joy1_btn = 8'h00;
  logic [7:0]        joy2_btn = 8'h00;
  logic [7:0]        rom [2**PRG_AW];

  assign prg_data = rom[prg_addr];

  always #5 clk = ~clk;

  cpu_bus_responder #(.RAM_AW(11), .PRG_AW(PRG_AW), .JOY_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .d_wr     (d_wr),
    .d_rd     (d_rd),
    .prg_addr (prg_addr),
    .prg_data (prg_data),
`ifdef JOY2_EN
    .joy2_btn (joy2_btn),
`endif
    .joy1_btn (joy1_btn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: d_rd=%h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a controller is a latched byte plus how many of its bits were read.
  logic [7:0] m_ram [2048];
  logic [7:0] m_rd;
  logic       m_strobe;
  logic [7:0] m_snap [2];
  int         m_reads [2];

  task automatic model_reset();
    m_rd       = 8'h00;
    m_strobe   = 1'b0;
    m_snap[0]  = 8'hFF;
    m_snap[1]  = 8'hFF;
    m_reads[0] = 0;
    m_reads[1] = 0;
  endtask

  task automatic joy_read(input int p, input logic [7:0] b, output logic [7:0] v);
    if (m_strobe) v = {7'b0, b[0]};
    else if (m_reads[p] < 8) begin
      v = {7'b0, m_snap[p][m_reads[p]]};
      m_reads[p]++;
    end else v = 8'h01;
  endtask

  task automatic model_step(input logic [15:0] a, input logic w, input logic [7:0] d,
                            input logic [7:0] b1, input logic [7:0] b2);
    if (w) begin
      if (a < 16'h2000) m_ram[a[10:0]] = d;
      else if (a == 16'h4016) begin
        if (m_strobe && !d[0]) begin
          m_snap[0]  = b1;
          m_snap[1]  = b2;
          m_reads[0] = 0;
          m_reads[1] = 0;
        end
        m_strobe = d[0];
      end
    end else begin
      if (a < 16'h2000) m_rd = m_ram[a[10:0]];
      else if (a == 16'h4016) joy_read(0, b1, m_rd);
      else if (a == 16'h4017 && JOY2) joy_read(1, b2, m_rd);
      else if (a >= 16'h8000) m_rd = rom[a[PRG_AW-1:0]];
    end
  endtask

  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d, input string tag);
    addr = a;
    we   = w;
    d_wr = d;
    @(posedge clk);
    model_step(a, w, d, joy1_btn, joy2_btn);
    #1 check(tag, d_rd, m_rd);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1 check(tag, d_rd, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [15:0] open_addr();
    logic [15:0] a;
    a = 16'(16'h2000 + $urandom_range(0, 16'h5FFF));
    if (a == 16'h4016 || a == 16'h4017) a = 16'h4015;
    return a;
  endfunction

  initial begin
    logic [15:0] a;
    int k;
    for (int i = 0; i < 2**PRG_AW; i++) rom[i] = 8'($urandom);
    model_reset();
    #12 check("reset_d_rd", d_rd, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < 2048; i++) bus(16'(i), 1'b1, 8'($urandom), "ram_init_hold");

    // Mirrored RAM reads, open bus, ROM write ignored
    bus(16'h0005, 1'b1, 8'h3C, "wr_hold");
    bus(16'h0805, 1'b0, 8'h00, "mirror_0805");
    check("mirror_0805_val", d_rd, 8'h3C);
    bus(16'h1005, 1'b0, 8'h00, "mirror_1005");
    bus(16'h1805, 1'b0, 8'h00, "mirror_1805");
    bus(16'h0005, 1'b0, 8'h00, "ram_0005");
    bus(16'h2002, 1'b0, 8'h00, "open_bus_2002");
    check("open_bus_val", d_rd, 8'h3C);
    bus(16'h8000, 1'b1, 8'hFF, "rom_write_hold");
    bus(16'h8000, 1'b0, 8'h00, "rom_unchanged");

    // Serial readout of a latched controller byte
    joy1_btn = 8'b1000_0101;
    bus(16'h4016, 1'b1, 8'h01, "strobe_on");
    bus(16'h4016, 1'b1, 8'h00, "strobe_off");
    joy1_btn = 8'h00;
    for (int i = 0; i < 9; i++) bus(16'h4016, 1'b0, 8'h00, "joy_serial");

    // Strobe held: live btn[0], no shifting
    bus(16'h4016, 1'b1, 8'h01, "strobe_hold_on");
    joy1_btn = 8'h01;
    bus(16'h4016, 1'b0, 8'h00, "live_btn1");
    joy1_btn = 8'h00;
    bus(16'h4016, 1'b0, 8'h00, "live_btn0");
    joy1_btn = 8'b0110_0011;
    bus(16'h4016, 1'b1, 8'h00, "strobe_release");
    for (int i = 0; i < 9; i++) bus(16'h4016, 1'b0, 8'h00, "joy_after_live");

    // Async reset mid-shift, RAM retained
    joy1_btn = 8'h00;
    bus(16'h4016, 1'b1, 8'h01, "strobe_on2");
    bus(16'h4016, 1'b1, 8'h00, "strobe_off2");
    for (int i = 0; i < 3; i++) bus(16'h4016, 1'b0, 8'h00, "pre_reset_rd");
    bus(16'h0005, 1'b0, 8'h00, "pre_reset_ram");
    async_reset("reset_mid_shift");
    for (int i = 0; i < 9; i++) bus(16'h4016, 1'b0, 8'h00, "post_reset_joy");
    bus(16'h0005, 1'b0, 8'h00, "ram_retained");
    check("ram_retained_val", d_rd, 8'h3C);

    // PRG mirror and $4017
    bus(16'h8123, 1'b0, 8'h00, "prg_8123");
    check("prg_8123_val", d_rd, rom[14'h0123]);
    bus(16'hC123, 1'b0, 8'h00, "prg_C123");
    check("prg_C123_val", d_rd, rom[14'h0123]);
    bus(16'h0005, 1'b0, 8'h00, "ram_before_4017");
    bus(16'h4017, 1'b0, 8'h00, "rd_4017");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) joy1_btn = 8'($urandom);
      if ($urandom_range(0, 7) == 0) joy2_btn = 8'($urandom);
      k = int'($urandom_range(0, 11));
      case (k)
        0, 1:  bus(16'($urandom_range(0, 16'h1FFF)), 1'b0, 8'h00, "rnd_ram_rd");
        2:     bus(16'($urandom_range(0, 16'h1FFF)), 1'b1, 8'($urandom), "rnd_ram_wr");
        3, 4:  bus(16'h4016, 1'b0, 8'h00, "rnd_joy1_rd");
        5:     bus(16'h4016, 1'b1, 8'($urandom), "rnd_strobe_wr");
        6:     bus(16'h4017, $urandom_range(0, 1) == 1, 8'($urandom), "rnd_4017");
        7, 8:  begin
          a = 16'($urandom_range(16'h8000, 16'hFFFF));
          bus(a, 1'b0, 8'h00, "rnd_prg_rd");
        end
        9:     bus(16'($urandom_range(16'h8000, 16'hFFFF)), 1'b1, 8'($urandom), "rnd_prg_wr");
        10:    bus(open_addr(), $urandom_range(0, 1) == 1, 8'($urandom), "rnd_open");
        default: begin
          if ($urandom_range(0, 40) == 0) async_reset("rnd_reset");
          else bus(open_addr(), 1'b0, 8'h00, "rnd_open_rd");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
